// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Holds the FSM state encoding, requester/select widths and the
// rotating-priority search used for both initial grants and handoffs.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SW    = 2;
  localparam int CW    = 8;   // quantum counter width, covers QUANTUM up to 255

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic          found;
    logic [SW-1:0] idx;
  } pick_t;

  // Search last+1, last+2, last+3, last+4 (mod 4) over req masked by excl.
  // Iterating from the farthest slot down lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SW-1:0]    last,
                                    input logic [N_REQ-1:0] excl);
    pick_t             p;
    logic [N_REQ-1:0]  elig;
    logic [SW-1:0]     k;
    p    = '0;
    elig = req & ~excl;
    for (int i = N_REQ; i >= 1; i--) begin
      k = last + SW'(i);
      if (elig[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between the four producers and the shared arbitrated output.
// master: producer/consumer side; slave: the arbiter.
interface mux4_rr_arbiter_if
  import mux4_arb_pkg::*;
#(
  parameter int DW = 4
);
  logic [N_REQ-1:0] req;
  logic [DW-1:0]    I0;
  logic [DW-1:0]    I1;
  logic [DW-1:0]    I2;
  logic [DW-1:0]    I3;
  logic [N_REQ-1:0] gnt;
  logic [SW-1:0]    s;
  logic [DW-1:0]    o;
  logic             o_vld;
  logic             busy;

  modport master (output req, I0, I1, I2, I3,
                  input  gnt, s, o, o_vld, busy);
  modport slave  (input  req, I0, I1, I2, I3,
                  output gnt, s, o, o_vld, busy);
endinterface

// File: rtl/mux4_rr_arbiter_dw.sv
// Combinational 4:1 word mux steered by the arbiter's select.
module mux4_dw
  import mux4_arb_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [N_REQ-1:0][DW-1:0] d_i,
  input  logic [SW-1:0]            sel_i,
  output logic [DW-1:0]            y_o
);
  assign y_o = d_i[sel_i];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 DW-bit datapath.
// Grants one requester at a time, hands off with no idle bubble when the
// holder drops req, and registers the selected word onto o/o_vld.
// Optional: define ARB_QUANTUM_EN to cap a holder at QUANTUM consecutive
// cycles while others are waiting.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW      = 4,
  parameter int QUANTUM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [SW-1:0]     s_q;
  logic [SW-1:0]     last_q;
  logic [DW-1:0]     o_q;
  logic              o_vld_q;

  logic [N_REQ-1:0]          req;
  logic [N_REQ-1:0][DW-1:0]  din;
  logic [DW-1:0]             mux_y;
  pick_t                     idle_pick;
  pick_t                     rel_pick;
  logic                      release_d;
  logic                      xfer;

  assign req = bus.req;
  assign din = {bus.I3, bus.I2, bus.I1, bus.I0};

  mux4_dw #(.DW(DW)) u_mux (
    .d_i   (din),
    .sel_i (s_q),
    .y_o   (mux_y)
  );

  // From IDLE the pointer is the last releaser; on handoff the holder is
  // both the pointer and excluded, so a same-cycle re-request is ignored.
  assign idle_pick = rr_pick(req, last_q, '0);
  assign rel_pick  = rr_pick(req, s_q, onehot(s_q));

`ifdef ARB_QUANTUM_EN
  logic [CW-1:0] cnt_q;
  logic          others;
  logic          q_hit;
  assign others    = |(req & ~onehot(s_q));
  assign q_hit     = (cnt_q == CW'(QUANTUM));
  assign release_d = ~req[s_q] | (q_hit & others);
`else
  assign release_d = ~req[s_q];
`endif

  // Arbitration FSM: grant, hold, handoff or return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      last_q  <= SW'(N_REQ - 1);
`ifdef ARB_QUANTUM_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_pick.found) begin
            state_q <= GRANT;
            gnt_q   <= onehot(idle_pick.idx);
            s_q     <= idle_pick.idx;
`ifdef ARB_QUANTUM_EN
            cnt_q   <= CW'(1);
`endif
          end
        end
        GRANT: begin
          if (release_d) begin
            last_q <= s_q;
            if (rel_pick.found) begin
              gnt_q <= onehot(rel_pick.idx);
              s_q   <= rel_pick.idx;
`ifdef ARB_QUANTUM_EN
              cnt_q <= CW'(1);
`endif
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end
`ifdef ARB_QUANTUM_EN
          else begin
            // Quantum reached with nobody else waiting: restart the window.
            cnt_q <= q_hit ? CW'(1) : cnt_q + CW'(1);
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign xfer = |(gnt_q & req);

  // Output register: capture the selected word only under a live grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      o_vld_q <= 1'b0;
    end else begin
      o_vld_q <= xfer;
      if (xfer) o_q <= mux_y;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.o     = o_q;
  assign bus.o_vld = o_vld_q;
  assign bus.busy  = |gnt_q;

endmodule
